frv_pipeline_dispatch_byp: RTL

- Parametrised next-generation dispatch stage (decode s2 -> execute s3) with an internal GPR file.
- Resolves RAW hazards by forwarding from NBYP later pipeline stages, and stalls only when a producer's data is not yet ready (load/CSR in flight).
- Selects operands A/B/C and registers them into the s3 pipeline register under a valid/busy handshake, with flush support.

---
 rtl/frv_dispatch_pkg.sv | 23 ++
 rtl/frv_dispatch_opsel.sv | 63 ++++++
 rtl/frv_pipeline_dispatch_byp.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/frv_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// frv_dispatch_pkg
//   Shared field widths for the dispatch stage, plus helpers that locate one
//   bypass lane inside the flattened byp_rd / byp_data buses.
// -----------------------------------------------------------------------------
package frv_dispatch_pkg;

   localparam int REG_W  = 5;
   localparam int UOP_W  = 5;
   localparam int FU_W   = 5;
   localparam int SIZE_W = 2;

   // LSB of bypass lane idx within the flattened byp_rd bus.
   function automatic int rd_lsb(input int idx);
      return idx * REG_W;
   endfunction

   // LSB of bypass lane idx within the flattened byp_data bus.
   function automatic int data_lsb(input int idx, input int xlen);
      return idx * xlen;
   endfunction

endpackage

// File: rtl/frv_dispatch_opsel.sv
// -----------------------------------------------------------------------------
// frv_dispatch_opsel
//   Resolves the value of one source register for the dispatch stage and
//   reports whether it must stall.
//   Priority: youngest matching bypass lane, then the GPR write port of this
//   cycle, then the register file. x0 always resolves to zero.
//
//   rs         source register address
//   byp_*      flattened bypass buses (lane 0 = youngest)
//   gpr_*      GPR write port of this cycle
//   rf_rdata   register file read data for rs
//   value      resolved operand value
//   hazard     winning producer cannot supply data yet
// -----------------------------------------------------------------------------
module frv_dispatch_opsel
   import frv_dispatch_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NBYP      = 3,
   parameter int BYPASS_EN = 1
) (
   input  logic [REG_W-1:0]      rs,
   input  logic [NBYP-1:0]       byp_valid,
   input  logic [NBYP-1:0]       byp_ready,
   input  logic [REG_W*NBYP-1:0] byp_rd,
   input  logic [XLEN*NBYP-1:0]  byp_data,
   input  logic                  gpr_wen,
   input  logic [REG_W-1:0]      gpr_rd,
   input  logic [XLEN-1:0]       gpr_wdata,
   input  logic [XLEN-1:0]       rf_rdata,
   output logic [XLEN-1:0]       value,
   output logic                  hazard
);

   logic hit;
   logic hit_ready;

   // Walk from the oldest lane to the youngest so the lowest-index match is
   // the last assignment and therefore wins.
   always_comb begin
      value     = rf_rdata;
      hit       = 1'b0;
      hit_ready = 1'b0;
      if (gpr_wen && (gpr_rd == rs))
         value = gpr_wdata;
      for (int i = NBYP - 1; i >= 0; i--) begin
         if (byp_valid[i] && (byp_rd[rd_lsb(i) +: REG_W] == rs)) begin
            hit       = 1'b1;
            hit_ready = byp_ready[i];
            value     = byp_data[data_lsb(i, XLEN) +: XLEN];
         end
      end
      // x0 has no producer: never forwarded, never stalls.
      if (rs == '0) begin
         value = '0;
         hit   = 1'b0;
      end
   end

   // Without forwarding, any in-flight producer of rs must retire first.
   assign hazard = hit & ((BYPASS_EN == 0) | ~hit_ready);

endmodule

// File: rtl/frv_pipeline_dispatch_byp.sv
// -----------------------------------------------------------------------------
// frv_pipeline_dispatch_byp
//   Dispatch stage between decode (s2) and execute (s3). Reads the GPR file,
//   forwards from NBYP later stages, stalls on producers whose data is not
//   ready, and registers operands A/B/C plus control fields into s3.
//
//   g_clk / g_resetn        clock, synchronous active-low reset
//   s2_*                    decoded instruction and valid/busy handshake
//   flush                   kill s3 and refuse s2 this cycle
//   byp_valid/ready/rd/data bypass sources, lane 0 youngest
//   gpr_wen/rd/wdata        GPR write-back port
//   s3_*                    registered instruction and valid/busy handshake
//   hzd_stall               s2 valid and blocked by a data hazard
// -----------------------------------------------------------------------------
module frv_pipeline_dispatch_byp
   import frv_dispatch_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NBYP      = 3,
   parameter int BYPASS_EN = 1
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,

   input  logic                  s2_p_valid,
   output logic                  s2_p_busy,
   input  logic [REG_W-1:0]      s2_rd,
   input  logic [REG_W-1:0]      s2_rs1,
   input  logic [REG_W-1:0]      s2_rs2,
   input  logic [31:0]           s2_imm,
   input  logic [31:0]           s2_pc,
   input  logic [UOP_W-1:0]      s2_uop,
   input  logic [FU_W-1:0]       s2_fu,
   input  logic                  s2_trap,
   input  logic [SIZE_W-1:0]     s2_size,
   input  logic [31:0]           s2_instr,
   input  logic                  s2_opa_pc,
   input  logic                  s2_opb_imm,

   input  logic                  flush,

   input  logic [NBYP-1:0]       byp_valid,
   input  logic [NBYP-1:0]       byp_ready,
   input  logic [REG_W*NBYP-1:0] byp_rd,
   input  logic [XLEN*NBYP-1:0]  byp_data,

   input  logic                  gpr_wen,
   input  logic [REG_W-1:0]      gpr_rd,
   input  logic [XLEN-1:0]       gpr_wdata,

   output logic [REG_W-1:0]      s3_rd,
   output logic [XLEN-1:0]       s3_opr_a,
   output logic [XLEN-1:0]       s3_opr_b,
   output logic [XLEN-1:0]       s3_opr_c,
   output logic [31:0]           s3_pc,
   output logic [UOP_W-1:0]      s3_uop,
   output logic [FU_W-1:0]       s3_fu,
   output logic                  s3_trap,
   output logic [SIZE_W-1:0]     s3_size,
   output logic [31:0]           s3_instr,
   output logic                  s3_p_valid,
   input  logic                  s3_p_busy,

   output logic                  hzd_stall
);

   // ---------------------------------------------------------------------
   // Register file. Entry 0 is never written; opsel forces x0 to zero.
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] rf [32];

   // NOTE: the register file has no reset -- software never reads a GPR
   // before writing it, and a reset would block mapping onto RAM.
   always_ff @(posedge g_clk) begin
      if (gpr_wen && (gpr_rd != '0))
         rf[gpr_rd] <= gpr_wdata;
   end

   // ---------------------------------------------------------------------
   // Source resolution
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic            rs1_hzd, rs2_hzd;

   frv_dispatch_opsel #(.XLEN(XLEN), .NBYP(NBYP), .BYPASS_EN(BYPASS_EN)) u_opsel_rs1 (
      .rs        (s2_rs1),
      .byp_valid (byp_valid),
      .byp_ready (byp_ready),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .gpr_wen   (gpr_wen),
      .gpr_rd    (gpr_rd),
      .gpr_wdata (gpr_wdata),
      .rf_rdata  (rf[s2_rs1]),
      .value     (rs1_val),
      .hazard    (rs1_hzd)
   );

   frv_dispatch_opsel #(.XLEN(XLEN), .NBYP(NBYP), .BYPASS_EN(BYPASS_EN)) u_opsel_rs2 (
      .rs        (s2_rs2),
      .byp_valid (byp_valid),
      .byp_ready (byp_ready),
      .byp_rd    (byp_rd),
      .byp_data  (byp_data),
      .gpr_wen   (gpr_wen),
      .gpr_rd    (gpr_rd),
      .gpr_wdata (gpr_wdata),
      .rf_rdata  (rf[s2_rs2]),
      .value     (rs2_val),
      .hazard    (rs2_hzd)
   );

   // rs1 is irrelevant when A takes the pc; rs2 always feeds operand C.
   logic hazard;
   assign hazard    = (rs1_hzd & ~s2_opa_pc) | rs2_hzd;
   assign hzd_stall = s2_p_valid & hazard;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic accept;
   assign s2_p_busy = hazard | (s3_p_valid & s3_p_busy) | flush;
   assign accept    = s2_p_valid & ~s2_p_busy;

   // ---------------------------------------------------------------------
   // Operand formatting: pc is zero-extended, imm sign-extended to XLEN.
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] pc_ext, imm_ext;

   generate
      if (XLEN > 32) begin : g_wide
         assign pc_ext  = {{(XLEN-32){1'b0}}, s2_pc};
         assign imm_ext = {{(XLEN-32){s2_imm[31]}}, s2_imm};
      end else begin : g_narrow
         assign pc_ext  = s2_pc[XLEN-1:0];
         assign imm_ext = s2_imm[XLEN-1:0];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // s3 pipeline register. Payload only loads on accept, so it holds while
   // s3 is stalled and after it drains.
   // ---------------------------------------------------------------------
   // NOTE: all state below uses non-blocking assignment so every s3 field
   // samples the pre-edge values of s2 and of s3_p_valid consistently.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         s3_p_valid <= 1'b0;
         s3_rd      <= '0;
         s3_opr_a   <= '0;
         s3_opr_b   <= '0;
         s3_opr_c   <= '0;
         s3_pc      <= '0;
         s3_uop     <= '0;
         s3_fu      <= '0;
         s3_trap    <= 1'b0;
         s3_size    <= '0;
         s3_instr   <= '0;
      end else begin
         if (flush) begin
            s3_p_valid <= 1'b0;
         end else if (accept) begin
            s3_p_valid <= 1'b1;
            s3_rd      <= s2_rd;
            s3_opr_a   <= s2_opa_pc  ? pc_ext  : rs1_val;
            s3_opr_b   <= s2_opb_imm ? imm_ext : rs2_val;
            s3_opr_c   <= rs2_val;
            s3_pc      <= s2_pc;
            s3_uop     <= s2_uop;
            s3_fu      <= s2_fu;
            s3_trap    <= s2_trap;
            s3_size    <= s2_size;
            s3_instr   <= s2_instr;
         end else if (!s3_p_busy) begin
            s3_p_valid <= 1'b0;
         end
      end
   end

endmodule
